// File: rtl/sm4_cbc_seq.sv
// rtl/sm4_cbc_seq.sv - ECB/CBC block-mode sequencer driving an SM4 cipher core
// Loads and expands a key, then chains 128-bit blocks through the core with a one-entry result register.
module sm4_cbc_seq #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [127:0] key_i,
    input  logic [1:0]   mode_i,
    input  logic         iv_valid_i,
    input  logic [127:0] iv_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         key_loaded_o,
    output logic         err_o,
    output logic         core_sm4_enable_o,
    output logic         core_encdec_enable_o,
    output logic         core_encdec_sel_o,
    output logic         core_valid_o,
    output logic [127:0] core_data_o,
    output logic         core_key_exp_o,
    output logic         core_key_valid_o,
    output logic [127:0] core_key_o,
    input  logic [127:0] core_result_i,
    input  logic         core_valid_out_i,
    input  logic         core_key_ready_i
);

    localparam logic [1:0] MODE_CBC_ENC = 2'b10;
    localparam logic [1:0] MODE_CBC_DEC = 2'b11;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_REQ,
        S_KEY_WAIT,
        S_READY,
        S_BLK_ISSUE,
        S_BLK_WAIT,
        S_OUT_HOLD,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic key_ready;
        logic blk_ready;
        logic out_valid;
        logic sm4_en;
        logic encdec_en;
        logic valid;
        logic key_exp;
        logic key_valid;
    } ctl_t;

    // Control outputs are registered alongside the state they belong to.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c           = '0;
        c.key_ready = (s == S_IDLE) || (s == S_READY) || (s == S_ERROR);
        c.blk_ready = (s == S_READY);
        c.out_valid = (s == S_OUT_HOLD);
        c.sm4_en    = !((s == S_IDLE) || (s == S_ERROR));
        c.encdec_en = (s == S_BLK_ISSUE) || (s == S_BLK_WAIT);
        c.valid     = (s == S_BLK_ISSUE);
        c.key_exp   = (s == S_KEY_REQ) || (s == S_KEY_WAIT);
        c.key_valid = (s == S_KEY_REQ);
        return c;
    endfunction

    state_t        state;
    ctl_t          ctl_q;
    logic [127:0]  key_q;
    logic [127:0]  chain_q;
    logic [127:0]  blk_q;
    logic [1:0]    mode_q;
    logic [127:0]  core_data_q;
    logic [127:0]  out_data_q;
    logic          key_loaded_q;
    logic          err_q;
    logic [TW-1:0] tmo_cnt;
    logic [127:0]  chain_in;

    // An IV arriving with the block it belongs to seeds that block's chaining.
    assign chain_in = iv_valid_i ? iv_i : chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            ctl_q        <= decode(S_IDLE);
            key_q        <= '0;
            chain_q      <= '0;
            blk_q        <= '0;
            mode_q       <= '0;
            core_data_q  <= '0;
            out_data_q   <= '0;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERROR: begin
                    if (key_valid_i) begin
                        key_q        <= key_i;
                        key_loaded_q <= 1'b0;
                        err_q        <= 1'b0;
                        state        <= S_KEY_REQ;
                        ctl_q        <= decode(S_KEY_REQ);
                    end
                end
                S_READY: begin
                    if (key_valid_i) begin
                        key_q        <= key_i;
                        key_loaded_q <= 1'b0;
                        err_q        <= 1'b0;
                        state        <= S_KEY_REQ;
                        ctl_q        <= decode(S_KEY_REQ);
                    end else begin
                        if (iv_valid_i) begin
                            chain_q <= iv_i;
                        end
                        if (in_valid_i) begin
                            mode_q      <= mode_i;
                            blk_q       <= in_data_i;
                            core_data_q <= (mode_i == MODE_CBC_ENC) ? (in_data_i ^ chain_in)
                                                                    : in_data_i;
                            state       <= S_BLK_ISSUE;
                            ctl_q       <= decode(S_BLK_ISSUE);
                        end
                    end
                end
                S_KEY_REQ: begin
                    tmo_cnt <= '0;
                    state   <= S_KEY_WAIT;
                    ctl_q   <= decode(S_KEY_WAIT);
                end
                S_KEY_WAIT: begin
                    if (tmo_cnt == TMO_LAST) begin
                        err_q        <= 1'b1;
                        key_loaded_q <= 1'b0;
                        state        <= S_ERROR;
                        ctl_q        <= decode(S_ERROR);
                    end else if (core_key_ready_i) begin
                        key_loaded_q <= 1'b1;
                        state        <= S_READY;
                        ctl_q        <= decode(S_READY);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_BLK_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_BLK_WAIT;
                    ctl_q   <= decode(S_BLK_WAIT);
                end
                S_BLK_WAIT: begin
                    // Timeout takes precedence over a result landing in the same cycle.
                    if (tmo_cnt == TMO_LAST) begin
                        err_q        <= 1'b1;
                        key_loaded_q <= 1'b0;
                        state        <= S_ERROR;
                        ctl_q        <= decode(S_ERROR);
                    end else if (core_valid_out_i) begin
                        out_data_q <= (mode_q == MODE_CBC_DEC) ? (core_result_i ^ chain_q)
                                                               : core_result_i;
                        if (mode_q == MODE_CBC_ENC) begin
                            chain_q <= core_result_i;
                        end else if (mode_q == MODE_CBC_DEC) begin
                            chain_q <= blk_q;
                        end
                        state <= S_OUT_HOLD;
                        ctl_q <= decode(S_OUT_HOLD);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_OUT_HOLD: begin
                    if (out_ready_i) begin
                        state <= S_READY;
                        ctl_q <= decode(S_READY);
                    end
                end
            endcase
        end
    end

    assign key_ready_o          = ctl_q.key_ready;
    assign in_ready_o           = ctl_q.blk_ready & ~key_valid_i;
    assign out_valid_o          = ctl_q.out_valid;
    assign out_data_o           = out_data_q;
    assign key_loaded_o         = key_loaded_q;
    assign err_o                = err_q;
    assign core_sm4_enable_o    = ctl_q.sm4_en;
    assign core_encdec_enable_o = ctl_q.encdec_en;
    assign core_encdec_sel_o    = mode_q[0];
    assign core_valid_o         = ctl_q.valid;
    assign core_data_o          = core_data_q;
    assign core_key_exp_o       = ctl_q.key_exp;
    assign core_key_valid_o     = ctl_q.key_valid;
    assign core_key_o           = key_q;

endmodule

// File: tb/tb_sm4_cbc_seq.sv
// tb/tb_sm4_cbc_seq.sv - scoreboard bench for sm4_cbc_seq with a behavioural cipher core
module tb_sm4_cbc_seq;

    localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;
    localparam int           KEY_LAT = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key = '0;
    logic [1:0]   mode = '0;
    logic         iv_valid = 1'b0;
    logic [127:0] iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         key_loaded;
    logic         err;
    logic         c_sm4_en, c_encdec_en, c_sel, c_valid, c_key_exp, c_key_valid;
    logic [127:0] c_data, c_key;
    logic [127:0] c_result = '0;
    logic         c_valid_out = 1'b0;
    logic         c_key_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cv    = 0;
    int n_kv    = 0;
    int blk_lat = 32;
    bit silent  = 1'b0;

    logic [127:0] exp_q[$];
    logic [127:0] cd_q[$];

    always #5 clk = ~clk;

    sm4_cbc_seq dut (
        .clk_i(clk), .rst_ni(rst_n),
        .key_valid_i(key_valid), .key_ready_o(key_ready), .key_i(key), .mode_i(mode),
        .iv_valid_i(iv_valid), .iv_i(iv),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .key_loaded_o(key_loaded), .err_o(err),
        .core_sm4_enable_o(c_sm4_en), .core_encdec_enable_o(c_encdec_en),
        .core_encdec_sel_o(c_sel), .core_valid_o(c_valid), .core_data_o(c_data),
        .core_key_exp_o(c_key_exp), .core_key_valid_o(c_key_valid), .core_key_o(c_key),
        .core_result_i(c_result), .core_valid_out_i(c_valid_out), .core_key_ready_i(c_key_ready)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in cipher: invertible mix, with the GB/T 32907 vector as a known answer.
    function automatic logic [127:0] toy_enc(input logic [127:0] k, input logic [127:0] x);
        logic [127:0] t;
        if (k == KAT_KEY && x == KAT_PT) return KAT_CT;
        t = x ^ k;
        return {t[114:0], t[127:115]} ^ {k[63:0], k[127:64]};
    endfunction

    function automatic logic [127:0] toy_dec(input logic [127:0] k, input logic [127:0] y);
        logic [127:0] t;
        if (k == KAT_KEY && y == KAT_CT) return KAT_PT;
        t = y ^ {k[63:0], k[127:64]};
        return {t[12:0], t[127:13]} ^ k;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural core: reacts just after each rising edge, independent of DUT reset.
    initial begin
        int key_cnt = 0;
        int blk_cnt = 0;
        logic [127:0] mdl_key = '0;
        logic [127:0] res = '0;
        forever begin
            @(posedge clk); #2;
            c_valid_out = 1'b0;
            if (c_key_valid) begin
                mdl_key     = c_key;
                c_key_ready = 1'b0;
                key_cnt     = KEY_LAT;
            end else if (key_cnt > 0) begin
                key_cnt--;
                if (key_cnt == 0) c_key_ready = 1'b1;
            end
            if (c_valid && !silent) begin
                res     = c_sel ? toy_dec(mdl_key, c_data) : toy_enc(mdl_key, c_data);
                blk_cnt = blk_lat;
            end else if (blk_cnt > 0) begin
                blk_cnt--;
                if (blk_cnt == 0) begin
                    c_valid_out = 1'b1;
                    c_result    = res;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (c_key_valid) n_kv++;
        if (c_valid) begin
            n_cv++;
            if (cd_q.size() > 0) check("core_data", c_data, cd_q.pop_front());
            else check("core_valid_unexpected", 128'(c_valid), 128'(0));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
            else check("out_valid_unexpected", 128'(out_valid), 128'(0));
        end
    end

    task automatic check_reset_outs(input string tag);
        check(tag, 128'({key_ready, in_ready, out_valid, key_loaded, err, c_sm4_en, c_encdec_en,
                         c_sel, c_valid, c_key_exp, c_key_valid}), 128'(11'b100_0000_0000));
        check({tag, "_data"}, out_data | c_data | c_key, '0);
    endtask

    task automatic load_key(input logic [127:0] k);
        int kr_at = -1;
        int cyc = 0;
        int kv0 = n_kv;
        bit done = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b1;
        key = k;
        @(negedge clk);
        @(posedge clk); #1;
        key_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (c_key_ready && kr_at < 0) kr_at = cyc;
            if (key_loaded) begin
                done = 1'b1;
                break;
            end
        end
        check("key_loaded_seen", 128'(done), 128'(1));
        check("key_loaded_lag", 128'(cyc - kr_at), 128'(1));
        check("key_strobe_count", 128'(n_kv - kv0), 128'(1));
        check("in_ready_after_key", 128'(in_ready), 128'(1));
    endtask

    task automatic load_iv(input logic [127:0] v);
        @(posedge clk); #1;
        iv_valid = 1'b1;
        iv = v;
        @(posedge clk); #1;
        iv_valid = 1'b0;
    endtask

    task automatic send_block(input logic [1:0] m, input logic [127:0] d,
                              input logic [127:0] exp_core, input logic [127:0] exp_out,
                              input bit push_out);
        bit ok = 1'b0;
        cd_q.push_back(exp_core);
        if (push_out) exp_q.push_back(exp_out);
        @(posedge clk); #1;
        in_valid = 1'b1;
        mode = m;
        in_data = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("in_accept", 128'(ok), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt1, pt2, ct1, ct2, ivv, ch, p, co, eo, held;
        logic [1:0]   m;
        int           cv0, n, vcount;

        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        load_key(KAT_KEY);

        cv0 = n_cv;
        send_block(2'b00, KAT_PT, KAT_PT, KAT_CT, 1'b1);
        drain();
        check("ecb_core_pulses", 128'(n_cv - cv0), 128'(1));
        send_block(2'b01, KAT_CT, KAT_CT, KAT_PT, 1'b1);
        drain();

        ivv = 128'h000102030405060708090a0b0c0d0e0f;
        pt1 = 128'h00112233445566778899aabbccddeeff;
        pt2 = 128'hfedcba98765432100123456789abcdef;
        ct1 = toy_enc(KAT_KEY, pt1 ^ ivv);
        ct2 = toy_enc(KAT_KEY, pt2 ^ ct1);
        load_iv(ivv);
        send_block(2'b10, pt1, pt1 ^ ivv, ct1, 1'b1);
        drain();
        send_block(2'b10, pt2, pt2 ^ ct1, ct2, 1'b1);
        drain();
        load_iv(ivv);
        send_block(2'b11, ct1, ct1, pt1, 1'b1);
        drain();
        send_block(2'b11, ct2, ct2, pt2, 1'b1);
        drain();

        ch = rnd128();
        load_iv(ch);
        for (int i = 0; i < 6; i++) begin
            m = 2'($urandom_range(0, 3));
            p = rnd128();
            case (m)
                2'b00: begin co = p;      eo = toy_enc(KAT_KEY, p); end
                2'b01: begin co = p;      eo = toy_dec(KAT_KEY, p); end
                2'b10: begin co = p ^ ch; eo = toy_enc(KAT_KEY, p ^ ch); ch = eo; end
                default: begin co = p;    eo = toy_dec(KAT_KEY, p) ^ ch; ch = p; end
            endcase
            send_block(m, p, co, eo, 1'b1);
            drain();
        end

        p = rnd128();
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_block(2'b00, p, p, toy_enc(KAT_KEY, p), 1'b1);
        n = 0;
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        check("bp_out_valid", 128'(out_valid), 128'(1));
        held = out_data;
        cv0 = n_cv;
        p = rnd128();
        cd_q.push_back(p);
        exp_q.push_back(toy_dec(KAT_KEY, p));
        @(posedge clk); #1;
        in_valid = 1'b1;
        mode = 2'b01;
        in_data = p;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data_stable", out_data, held);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        check("bp_no_issue", 128'(n_cv - cv0), 128'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        check("bp_release_accept", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        silent = 1'b1;
        p = rnd128();
        send_block(2'b00, p, p, '0, 1'b0);
        n = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (err) break;
            if (c_encdec_en && !c_valid) n++;
        end
        check("tmo_wait_cycles", 128'(n), 128'(1024));
        check("tmo_err", 128'(err), 128'(1));
        check("tmo_state", 128'({in_ready, key_loaded, c_sm4_en, c_encdec_en, c_valid, key_ready}),
              128'(6'b000001));
        silent = 1'b0;
        load_key(KAT_KEY);
        check("tmo_err_cleared", 128'(err), 128'(0));

        p = rnd128();
        send_block(2'b00, p, p, '0, 1'b0);
        repeat (5) @(negedge clk);
        check("rst_in_wait", 128'(c_encdec_en), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outs("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("post_reset_no_out", 128'(vcount), 128'(0));
        check_reset_outs("post_reset");
        check("queues_empty", 128'(exp_q.size() + cd_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sm4_cbc_seq.md
Name: sm4_cbc_seq

Overview:
- Block-mode sequencer placed directly upstream of the sm4_top cipher core, alongside the TL-UL register wrapper.
- Accepts a key and a stream of 128-bit blocks over valid/ready handshakes and drives the core's control and data pins.
- Performs key expansion, then ECB or CBC encrypt/decrypt with chaining-value XOR.
- Returns results over a valid/ready output with a one-entry output register.

Parameters:
- TIMEOUT, 1024: cycle budget for any single core operation (key expansion or block) before the error state is entered.
- TW, 11: timeout counter width; TW ≥ clog2(TIMEOUT+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- key_valid_i  in  1  load new key; accepted only when key_ready_o=1
- key_ready_o  out  1  high in IDLE, READY and ERROR
- key_i  in  128  user key
- mode_i  in  2  sampled at accept: 00 ECB-enc, 01 ECB-dec, 10 CBC-enc, 11 CBC-dec
- iv_valid_i  in  1  load chaining value; accepted in READY only
- iv_i  in  128  initial chaining value
- in_valid_i  in  1  input block valid
- in_ready_o  out  1  input block accepted when in_valid_i & in_ready_o
- in_data_i  in  128  input block
- out_valid_o  out  1  result valid; held until out_ready_i
- out_ready_i  in  1  downstream ready
- out_data_o  out  128  result block
- key_loaded_o  out  1  expanded key available
- err_o  out  1  sticky timeout flag; cleared only by a new key load
- core_sm4_enable_o  out  1  core enable; high in every state except IDLE and ERROR
- core_encdec_enable_o  out  1  high in BLK_ISSUE and BLK_WAIT
- core_encdec_sel_o  out  1  0 = encrypt, 1 = decrypt (mode_i[0] of the current block)
- core_valid_o  out  1  one-cycle block-start strobe
- core_data_o  out  128  block presented to the core
- core_key_exp_o  out  1  key-expansion enable; high in KEY_REQ and KEY_WAIT
- core_key_valid_o  out  1  one-cycle key strobe
- core_key_o  out  128  registered key
- core_result_i  in  128  core result
- core_valid_out_i  in  1  core result-valid pulse
- core_key_ready_i  in  1  core key-expansion-done level

Behaviour:
- Reset: FSM=IDLE. All outputs 0 except key_ready_o=1. Key, IV, chain and output registers cleared; timeout counter 0.
- Reset mid-operation: same result; any in-flight core result is discarded.
- FSM states: IDLE, KEY_REQ, KEY_WAIT, READY, BLK_ISSUE, BLK_WAIT, OUT_HOLD, ERROR.
- Key load (IDLE/READY/ERROR):
  - key_valid_i registers key_i; key_loaded_o and err_o are cleared; go to KEY_REQ.
  - KEY_REQ lasts 1 cycle: core_key_valid_o=1, core_key_exp_o=1; go to KEY_WAIT.
  - KEY_WAIT exits when core_key_ready_i=1: set key_loaded_o, go to READY.
- IV load: iv_valid_i in READY loads the chain register (1 cycle, no state change). If key_valid_i and iv_valid_i arrive in the same READY cycle, the key wins and the IV is ignored.
- in_ready_o = (state==READY) & ~key_valid_i.
- Block accept (READY): latch mode_i and in_data_i; go to BLK_ISSUE.
- Value driven on core_data_o:
  - ECB-enc, ECB-dec, CBC-dec: in_data
  - CBC-enc: in_data XOR chain
- BLK_ISSUE lasts 1 cycle with core_valid_o=1; go to BLK_WAIT.
- BLK_WAIT exits on core_valid_out_i=1. core_result_i is registered into out_data_o:
  - ECB-enc, ECB-dec, CBC-enc: core_result_i
  - CBC-dec: core_result_i XOR chain
- Chain update at result capture:
  - CBC-enc: chain = core_result_i
  - CBC-dec: chain = the latched input ciphertext
  - ECB: chain unchanged
- After capture: out_valid_o=1, go to OUT_HOLD.
- OUT_HOLD: out_data_o is stable while out_valid_o & ~out_ready_i. On out_ready_i go to READY; the next block can be accepted one cycle later.
- Throughput: one block per (core latency + 3) cycles.
- Timeout:
  - Counter clears on entry to KEY_WAIT or BLK_WAIT and increments each cycle in those states.
  - When it reaches TIMEOUT: err_o=1, key_loaded_o=0, go to ERROR.
  - ERROR: all core strobes and enables are 0; in_ready_o=0; only a key load exits.
- core_valid_out_i or core_key_ready_i seen outside its WAIT state is ignored. A core result arriving in the same cycle the timeout is reached is dropped (timeout wins).
- key_valid_i is ignored in KEY_REQ, KEY_WAIT, BLK_ISSUE, BLK_WAIT and OUT_HOLD.

Test Plan:
- Key 0123456789abcdeffedcba9876543210; model core returns key_ready after 32 cycles -> one core_key_valid_o pulse, key_loaded_o rises the cycle after key_ready, in_ready_o=1.
- ECB-enc of 0123456789abcdeffedcba9876543210 with the GB/T 32907 key above; model core latency 32 -> out_data_o=681edf34d206965e86b3e94f536e4246, one core_valid_o pulse.
- CBC-enc: IV=000102..0f, two blocks; then CBC-dec of the two ciphertexts with the same IV -> original plaintexts recovered; core_data_o of block 2 = pt2 XOR ct1.
- Backpressure: out_ready_i low for 10 cycles -> out_data_o stable, in_ready_o=0, no second core_valid_o pulse.
- Core never returns valid_out with TIMEOUT=1024 -> err_o=1 at cycle 1024 of BLK_WAIT, in_ready_o=0; new key load clears err_o.
- Assert rst_ni during BLK_WAIT -> all outputs return to reset values; a later core_valid_out_i produces no output.
